// File: rtl/tlu_trigger_emulator.sv
// TLU-side trigger emulator.
// Issues triggers on TLU_TRIGGER and runs the EUDET-style handshake against
// the DUT's TLU_BUSY / TLU_CLOCK. It supports three modes: pulse only,
// simple busy handshake, and serial trigger-number handshake.
module tlu_trigger_emulator #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        START,
  input  logic [1:0]  MODE,
  input  logic [7:0]  TRIGGER_LENGTH,
  input  logic [15:0] BUSY_TIMEOUT,
  input  logic        DATA_MSB_FIRST,
  input  logic        LOAD_NUMBER,
  input  logic [30:0] NUMBER_IN,
  input  logic        TLU_BUSY,
  input  logic        TLU_CLOCK,
  output logic        TLU_TRIGGER,
  output logic [30:0] TRIGGER_NUMBER,
  output logic        READY,
  output logic        BUSY_TIMEOUT_ERROR,
  output logic [15:0] MISSED_TRIGGERS
);

  // The holdoff counter only has to reach HOLDOFF_CYCLES-1.
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_BUSY_HIGH,
    SHIFT_DATA,
    WAIT_BUSY_LOW,
    HOLDOFF
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] busy_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   busy_s;
  logic                   clk_s;
  logic                   clk_s_d;
  logic                   clk_rise;

  logic              trigger_q, trigger_next;
  logic [30:0]       number_q, number_next;
  logic              error_q, error_next;
  logic [15:0]       missed_q, missed_next;
  logic [1:0]        mode_q, mode_next;
  logic [7:0]        len_cnt, len_cnt_next;
  logic [15:0]       timeout_cnt, timeout_cnt_next;
  logic [30:0]       shift_q, shift_next;
  logic [5:0]        edge_cnt, edge_cnt_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;

  logic [7:0]  eff_length;
  logic        timeout_hit;
  logic [30:0] number_inc;

  // Mirror a 31-bit word so the shifter can always emit from bit 0.
  function automatic logic [30:0] reverse31(input logic [30:0] value);
    logic [30:0] result;
    result = '0;
    for (int i = 0; i < 31; i++) begin
      result[i] = value[30 - i];
    end
    return result;
  endfunction

  // Bring the asynchronous DUT handshake lines into the CLK domain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_sync <= '0;
      clk_sync  <= '0;
      clk_s_d   <= 1'b0;
    end else begin
      busy_sync <= {busy_sync[SYNC_STAGES-2:0], TLU_BUSY};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], TLU_CLOCK};
      clk_s_d   <= clk_s;
    end
  end

  assign busy_s   = busy_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_s_d;

  assign eff_length  = (TRIGGER_LENGTH == 8'd0) ? 8'd1 : TRIGGER_LENGTH;
  assign timeout_hit = (BUSY_TIMEOUT != 16'd0) &&
                       (({1'b0, timeout_cnt} + 17'd1) >= {1'b0, BUSY_TIMEOUT});
  assign number_inc  = number_q + 31'd1;

  // State and datapath registers; everything returns to idle on RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      trigger_q   <= 1'b0;
      number_q    <= '0;
      error_q     <= 1'b0;
      missed_q    <= '0;
      mode_q      <= '0;
      len_cnt     <= '0;
      timeout_cnt <= '0;
      shift_q     <= '0;
      edge_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_next;
      trigger_q   <= trigger_next;
      number_q    <= number_next;
      error_q     <= error_next;
      missed_q    <= missed_next;
      mode_q      <= mode_next;
      len_cnt     <= len_cnt_next;
      timeout_cnt <= timeout_cnt_next;
      shift_q     <= shift_next;
      edge_cnt    <= edge_cnt_next;
      hold_cnt    <= hold_cnt_next;
    end
  end

  // Next-state and datapath decisions for the handshake sequence.
  always_comb begin
    state_next       = state;
    trigger_next     = trigger_q;
    number_next      = number_q;
    error_next       = error_q;
    missed_next      = missed_q;
    mode_next        = mode_q;
    len_cnt_next     = len_cnt;
    timeout_cnt_next = timeout_cnt;
    shift_next       = shift_q;
    edge_cnt_next    = edge_cnt;
    hold_cnt_next    = hold_cnt;

    if (START && ENABLE && (state != IDLE) && (missed_q != 16'hFFFF)) begin
      missed_next = missed_q + 16'd1;
    end

    case (state)
      IDLE: begin
        trigger_next = 1'b0;
        if (LOAD_NUMBER) begin
          number_next = NUMBER_IN;
        end
        if (START && ENABLE) begin
          trigger_next     = 1'b1;
          error_next       = 1'b0;
          mode_next        = MODE;
          len_cnt_next     = 8'd1;
          timeout_cnt_next = '0;
          state_next       = (MODE == 2'd0) ? PULSE : WAIT_BUSY_HIGH;
        end
      end

      PULSE: begin
        if (len_cnt >= eff_length) begin
          trigger_next  = 1'b0;
          number_next   = number_inc;
          hold_cnt_next = '0;
          state_next    = HOLDOFF;
        end else begin
          len_cnt_next = len_cnt + 8'd1;
        end
      end

      WAIT_BUSY_HIGH: begin
        if (busy_s) begin
          trigger_next     = 1'b0;
          timeout_cnt_next = '0;
          if (mode_q == 2'd1) begin
            state_next = WAIT_BUSY_LOW;
          end else begin
            shift_next    = DATA_MSB_FIRST ? reverse31(number_q) : number_q;
            edge_cnt_next = '0;
            state_next    = SHIFT_DATA;
          end
        end else if (timeout_hit) begin
          trigger_next     = 1'b0;
          error_next       = 1'b1;
          timeout_cnt_next = '0;
          hold_cnt_next    = '0;
          state_next       = HOLDOFF;
        end else begin
          timeout_cnt_next = timeout_cnt + 16'd1;
        end
      end

      SHIFT_DATA: begin
        if (!busy_s) begin
          trigger_next  = 1'b0;
          number_next   = number_inc;
          hold_cnt_next = '0;
          state_next    = HOLDOFF;
        end else if (clk_rise) begin
          trigger_next = (edge_cnt < 6'd31) ? shift_q[0] : 1'b0;
          shift_next   = {1'b0, shift_q[30:1]};
          if (edge_cnt != 6'd32) begin
            edge_cnt_next = edge_cnt + 6'd1;
          end
        end
      end

      WAIT_BUSY_LOW: begin
        trigger_next = 1'b0;
        if (!busy_s) begin
          number_next   = number_inc;
          hold_cnt_next = '0;
          state_next    = HOLDOFF;
        end
      end

      HOLDOFF: begin
        trigger_next = 1'b0;
        if (hold_cnt == HOLD_LAST) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end

      default: begin
        trigger_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  assign TLU_TRIGGER        = trigger_q;
  assign TRIGGER_NUMBER     = number_q;
  assign READY              = (state == IDLE);
  assign BUSY_TIMEOUT_ERROR = error_q;
  assign MISSED_TRIGGERS    = missed_q;

endmodule
